// File: rtl/wait_state_memory.sv
// wait_state_memory
//   Word-addressed memory with a fixed number of wait states per access and a
//   simulation-halt mailbox. Bit numbering is big-endian: bit 0 is the MSB.
//
//   Ports
//     clock     : single clock, all state changes on the rising edge
//     reset     : synchronous active-high reset (storage is not touched)
//     req       : access request, only sampled while idle
//     write_en  : 1 = write, 0 = read (qualified by req)
//     address   : [15:31] word address; low DEPTH_LOG2 bits index storage
//     byte_en   : [0:3] lane enables, bit 0 covers data bits 0:7
//     data_in   : [0:31] write data
//     data_out  : [0:31] read data, loaded only when a read completes
//     ready     : one-cycle strobe marking access completion
//     busy      : high while an access is in progress
//     sim_end   : sticky flag, set when the halt mailbox is written
module wait_state_memory #(
  parameter int           DEPTH_LOG2  = 9,
  parameter int           WAIT_STATES = 2,
  parameter logic [15:31] HALT_ADDR   = 17'h00100,
  parameter logic [0:31]  HALT_DATA   = 32'h00010001
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         write_en,
  input  logic [15:31] address,
  input  logic [0:3]   byte_en,
  input  logic [0:31]  data_in,
  output logic [0:31]  data_out,
  output logic         ready,
  output logic         busy,
  output logic         sim_end
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [1:0]   state;
  logic [3:0]   cnt;

  // Access fields latched when a request is accepted
  logic         we_q;
  logic [15:31] addr_q;
  logic [0:3]   be_q;
  logic [0:31]  data_q;

  // Storage comes up zeroed; it may be preloaded externally at time zero.
  logic [0:31]  mem [0:DEPTH-1] = '{default: '0};

  // With zero wait states the access completes on the very edge that accepts
  // it, so the live inputs are used while idle and the latched copy otherwise.
  logic                  in_idle;
  logic                  acc_we;
  logic [15:31]          acc_addr;
  logic [0:3]            acc_be;
  logic [0:31]           acc_data;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  enter_done;
  logic                  halt_hit;

  assign in_idle  = (state == IDLE);
  assign acc_we   = in_idle ? write_en : we_q;
  assign acc_addr = in_idle ? address  : addr_q;
  assign acc_be   = in_idle ? byte_en  : be_q;
  assign acc_data = in_idle ? data_in  : data_q;

  // Low address bits select the word; higher bits alias.
  assign acc_idx  = acc_addr[32-DEPTH_LOG2 +: DEPTH_LOG2];

  assign enter_done = (in_idle && req && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // Mailbox compare uses the full address, before aliasing.
  assign halt_hit = acc_we && (acc_addr == HALT_ADDR) &&
                    (acc_be == 4'b1111) && (acc_data == HALT_DATA);

  assign busy = !in_idle;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      data_out <= '0;
      sim_end  <= 1'b0;
    end else begin
      ready <= enter_done;
      case (state)
        IDLE: if (req) begin
          we_q   <= write_en;
          addr_q <= address;
          be_q   <= byte_en;
          data_q <= data_in;
          cnt    <= WS;
          state  <= (WAIT_STATES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_done && !acc_we) data_out <= mem[acc_idx];
      if (enter_done && halt_hit) sim_end <= 1'b1;
    end
  end

  // Write commit; reset on the commit edge aborts the access.
  always_ff @(posedge clock) begin
    if (!reset && enter_done && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wait_state_memory.sv
module tb_wait_state_memory;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;

  // Main instance (WAIT_STATES = 2)
  logic        req, we;
  logic [16:0] addr;
  logic [3:0]  be;
  logic [31:0] din, dout;
  logic        ready, busy, sim_end;

  // Zero-wait-state instance
  logic        req0, we0;
  logic [16:0] addr0;
  logic [3:0]  be0;
  logic [31:0] din0, dout0;
  logic        ready0, busy0, sim_end0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wait_state_memory #(.DEPTH_LOG2(9), .WAIT_STATES(WS)) dut (
    .clock(clk), .reset(rst), .req(req), .write_en(we), .address(addr),
    .byte_en(be), .data_in(din), .data_out(dout), .ready(ready),
    .busy(busy), .sim_end(sim_end));

  wait_state_memory #(.DEPTH_LOG2(9), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(rst), .req(req0), .write_en(we0), .address(addr0),
    .byte_en(be0), .data_in(din0), .data_out(dout0), .ready(ready0),
    .busy(busy0), .sim_end(sim_end0));

  // Reference model: plain array of words plus output state
  logic [31:0] mem_m [512];
  logic [31:0] dout_m;
  logic        sim_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_apply(input bit w, input logic [16:0] a, input logic [3:0] b,
                             input logic [31:0] d);
    int unsigned idx;
    logic [31:0] mask;
    idx = int'(a) % 512;
    mask = '0;
    for (int k = 0; k < 4; k++) if (b[k]) mask[8*k +: 8] = 8'hFF;
    if (w) begin
      mem_m[idx] = (mem_m[idx] & ~mask) | (d & mask);
      if (a == 17'h00100 && b == 4'hF && d == 32'h00010001) sim_m = 1'b1;
    end else begin
      dout_m = mem_m[idx];
    end
  endtask

  // One access on the main instance. Checks completion latency and the
  // one-cycle ready pulse. With hold set, req stays high with scrambled
  // inputs during the wait so that ignored requests are exercised.
  task automatic access(input bit w, input logic [16:0] a, input logic [3:0] b,
                        input logic [31:0] d, input bit hold);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; din = d;
    @(posedge clk);
    model_apply(w, a, b, d);
    n = 0;
    forever begin
      @(negedge clk);
      if (hold) begin
        req = 1'b1; we = $urandom_range(0, 1); addr = 17'($urandom);
        be = 4'($urandom); din = $urandom;
      end else begin
        req = 1'b0;
      end
      if (ready) break;
      if (!busy) begin chk("busy_during_wait", busy, 1'b1); break; end
      if (n >= 20) begin chk("ready_timeout", n, WS); break; end
      @(posedge clk);
      n++;
    end
    req = 1'b0;
    chk("latency", n, WS);
    @(posedge clk);
    @(negedge clk);
    chk("ready_one_cycle", ready, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic rd0(input logic [16:0] a, input logic [31:0] exp);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = a;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    chk("ws0_read_ready", ready0, 1'b1);
    chk("ws0_read_data", dout0, exp);
    @(posedge clk);
  endtask

  typedef struct {
    bit          w;
    logic [16:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp_dout;
    bit          exp_sim;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1, 17'h00005, 4'hF, 32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{0, 17'h00005, 4'hF, 32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1, 17'h00007, 4'hF, 32'h11223344, 32'hDEADBEEF, 0};
    vecs[3]  = '{1, 17'h00007, 4'b0100, 32'hAABBCCDD, 32'hDEADBEEF, 0};
    vecs[4]  = '{0, 17'h00007, 4'h0, 32'h0,        32'h11BB3344, 0};
    vecs[5]  = '{1, 17'h00203, 4'hF, 32'h00000077, 32'h11BB3344, 0};
    vecs[6]  = '{0, 17'h00003, 4'hF, 32'h0,        32'h00000077, 0};
    vecs[7]  = '{1, 17'h00300, 4'hF, 32'h00010001, 32'h00000077, 0};
    vecs[8]  = '{0, 17'h00100, 4'hF, 32'h0,        32'h00010001, 0};
    vecs[9]  = '{1, 17'h00005, 4'h0, 32'hFFFFFFFF, 32'h00010001, 0};
    vecs[10] = '{0, 17'h00005, 4'hF, 32'h0,        32'hDEADBEEF, 0};
    vecs[11] = '{1, 17'h00100, 4'hF, 32'h00010001, 32'hDEADBEEF, 1};
    vecs[12] = '{0, 17'h01005, 4'hF, 32'h0,        32'hDEADBEEF, 1};

    for (int i = 0; i < 512; i++) mem_m[i] = '0;
    dout_m = '0; sim_m = 1'b0;
    req = 0; we = 0; addr = '0; be = '0; din = '0;
    req0 = 0; we0 = 0; addr0 = '0; be0 = 4'hF; din0 = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sim_end", sim_end, 1'b0);
    chk("rst_data_out", dout, 32'h0);
    chk("rst_ws0_data_out", dout0, 32'h0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].d, i[0]);
      chk($sformatf("vec%0d_data_out", i), dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_sim_end", i), sim_end, vecs[i].exp_sim);
    end

    // Reset on the commit edge aborts the write
    begin
      int pulses;
      pulses = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 17'h00010; be = 4'hF; din = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      pulses += int'(ready);
      @(posedge clk);
      @(negedge clk);
      pulses += int'(ready);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_sim_end_cleared", sim_end, 1'b0);
      chk("abort_data_out", dout, 32'h0);
      for (int k = 0; k < 4; k++) begin
        pulses += int'(ready);
        @(negedge clk);
      end
      chk("abort_ready_pulses", pulses, 0);
      dout_m = '0; sim_m = 1'b0;
      access(1'b0, 17'h00010, 4'hF, 32'h0, 1'b0);
      chk("abort_no_commit", dout, 32'h0);
    end

    // Reset wins over a same-cycle request
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 17'h00005;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("rst_vs_req_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_vs_req_ready", ready, 1'b0);

    // Randomised accesses against the model
    for (int i = 0; i < 150; i++) begin
      bit          w;
      logic [16:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      w = $urandom_range(0, 1);
      a = 17'(($urandom_range(0, 3) << 9) | $urandom_range(0, 15));
      b = 4'($urandom);
      d = $urandom;
      if (i % 60 == 59) begin w = 1; a = 17'h00100; b = 4'hF; d = 32'h00010001; end
      access(w, a, b, d, $urandom_range(0, 1));
      chk("rand_data_out", dout, dout_m);
      chk("rand_sim_end", sim_end, sim_m);
    end

    // Zero wait states: req held for 6 edges, accepted every second edge
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF;
    for (int k = 0; k < 6; k++) begin
      addr0 = 17'(k); din0 = 32'(k + 100);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ws0_ready_edge%0d", k), ready0, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    req0 = 1'b0;
    @(posedge clk);
    rd0(17'h00002, 32'd102);
    rd0(17'h00001, 32'd0);
    rd0(17'h00004, 32'd104);
    chk("ws0_sim_end", sim_end0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
